// File: rtl/reconfig_pkg.sv
// Shared FSM encoding and width helpers for the reconfig_ctrl remote-update controller.
package reconfig_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_WATCH,
      ST_ERR,
      ST_FAIL
   } state_t;

   // Bits needed to hold every value in 0..max_value (never less than one).
   function automatic int cnt_width(input int max_value);
      int w = 1;
      while ((longint'(1) << w) <= longint'(max_value)) w++;
      return w;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/reconfig_sync2.sv
// Two-flop synchroniser for the asynchronous cfg_ERROR status from the reconfiguration primitive.
module reconfig_sync2 (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: clocked state uses non-blocking assignments so meta->q shifts by one stage per edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reconfig_ctrl.sv
// Remote-update controller sequencing ENA/CBSEL setup, the CONFIG pulse and the error watch window.
// Define RECFG_RETRY_EN to retry the same image up to RETRY_MAX times before failing.
module reconfig_ctrl
   import reconfig_pkg::*;
#(
   parameter int CBSEL_W         = 2,
   parameter int DEFAULT_IMAGE   = 1,
   parameter int CNT_W           = 24,
   parameter int TIMEOUT_CYCLES  = 1749000,
   parameter int SETUP_CYCLES    = 4,
   parameter int PULSE_CYCLES    = 16,
   parameter int ERR_WAIT_CYCLES = 1024,
   parameter int RETRY_MAX       = 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               auto_en,
   input  logic               req,
   input  logic [CBSEL_W-1:0] req_image,
   output logic               busy,
   output logic               fail,
   output logic [CBSEL_W-1:0] cfg_CBSEL,
   output logic               cfg_ENA,
   output logic               cfg_CONFIG,
   input  logic               cfg_ERROR,
   output logic               cfg_ERROR_port
);

   localparam int TMR_W = cnt_width(max3(SETUP_CYCLES, PULSE_CYCLES, ERR_WAIT_CYCLES));

   // SETUP also covers the accept cycle, so CONFIG rises 1 + SETUP_CYCLES after accept.
   localparam logic [TMR_W-1:0]   SETUP_LAST = TMR_W'(SETUP_CYCLES);
   localparam logic [TMR_W-1:0]   PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   WATCH_LAST = TMR_W'(ERR_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   AUTO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CBSEL_W-1:0] AUTO_IMAGE = CBSEL_W'(DEFAULT_IMAGE);

   state_t             state, state_d;
   logic [TMR_W-1:0]   tmr, tmr_d;
   logic [CNT_W-1:0]   auto_cnt, auto_d;
   logic               busy_d, fail_d, ena_d, config_d;
   logic [CBSEL_W-1:0] cbsel_d;
   logic               auto_hit, accept;

`ifdef RECFG_RETRY_EN
   localparam int RETRY_W = cnt_width(RETRY_MAX);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX);
   logic [RETRY_W-1:0] retry_cnt, retry_d;
`else
   // Without retries the limit has no effect.
   logic unused_retry;
   assign unused_retry = (RETRY_MAX != 0);
`endif

   reconfig_sync2 u_err_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (cfg_ERROR),
      .q    (cfg_ERROR_port)
   );

   // An external req in the same cycle as the terminal count wins the image select.
   assign auto_hit = (state == ST_IDLE) && auto_en && !fail && (auto_cnt == AUTO_LAST);
   assign accept   = ((state == ST_IDLE) && (req || auto_hit)) || ((state == ST_FAIL) && req);

   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_d  = state;
      tmr_d    = tmr;
      auto_d   = '0;
      busy_d   = busy;
      fail_d   = fail;
      ena_d    = cfg_ENA;
      config_d = cfg_CONFIG;
      cbsel_d  = cfg_CBSEL;
`ifdef RECFG_RETRY_EN
      retry_d  = retry_cnt;
`endif
      if ((state == ST_IDLE) && auto_en && !fail && !req && !auto_hit)
         auto_d = auto_cnt + 1'b1;

      case (state)
         ST_IDLE, ST_FAIL: state_d = ST_IDLE;
         ST_SETUP: begin
            if (tmr == SETUP_LAST) begin
               state_d  = ST_PULSE;
               tmr_d    = '0;
               config_d = 1'b1;
            end else tmr_d = tmr + 1'b1;
         end
         ST_PULSE: begin
            if (tmr == PULSE_LAST) begin
               state_d  = ST_WATCH;
               tmr_d    = '0;
               config_d = 1'b0;
            end else tmr_d = tmr + 1'b1;
         end
         ST_WATCH: begin
            if (cfg_ERROR_port) begin
               state_d = ST_ERR;
               tmr_d   = '0;
               ena_d   = 1'b0;
            end else if (tmr == WATCH_LAST) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
               busy_d  = 1'b0;
               ena_d   = 1'b0;
            end else tmr_d = tmr + 1'b1;
         end
         ST_ERR: begin
`ifdef RECFG_RETRY_EN
            if (retry_cnt < RETRY_LAST) begin
               state_d = ST_SETUP;
               retry_d = retry_cnt + 1'b1;
               tmr_d   = '0;
               ena_d   = 1'b1;
            end else begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               busy_d  = 1'b0;
            end
`else
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         state_d = ST_SETUP;
         tmr_d   = '0;
         busy_d  = 1'b1;
         fail_d  = 1'b0;
         ena_d   = 1'b1;
         cbsel_d = req ? req_image : AUTO_IMAGE;
`ifdef RECFG_RETRY_EN
         retry_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         tmr        <= '0;
         auto_cnt   <= '0;
         busy       <= 1'b0;
         fail       <= 1'b0;
         cfg_ENA    <= 1'b0;
         cfg_CONFIG <= 1'b0;
         cfg_CBSEL  <= '0;
`ifdef RECFG_RETRY_EN
         retry_cnt  <= '0;
`endif
      end else begin
         state      <= state_d;
         tmr        <= tmr_d;
         auto_cnt   <= auto_d;
         busy       <= busy_d;
         fail       <= fail_d;
         cfg_ENA    <= ena_d;
         cfg_CONFIG <= config_d;
         cfg_CBSEL  <= cbsel_d;
`ifdef RECFG_RETRY_EN
         retry_cnt  <= retry_d;
`endif
      end
   end

endmodule

// File: tb/tb_reconfig_ctrl.sv
// Directed self-checking bench for reconfig_ctrl. Cycle c spans posedge c-1 .. posedge c,
// cycle 1 starts at reset release; outputs are observed at the negedge inside each cycle.
module tb_reconfig_ctrl;

   localparam int CBSEL_W = 2;

`ifdef RECFG_RETRY_EN
   localparam int EXP_PULSES = 3;
   localparam int EXP_FAIL   = 82;
`else
   localparam int EXP_PULSES = 1;
   localparam int EXP_FAIL   = 36;
`endif

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               auto_en = 1'b0;
   logic               req = 1'b0;
   logic [CBSEL_W-1:0] req_image = '0;
   logic               cfg_ERROR = 1'b0;
   logic               busy, fail, cfg_ENA, cfg_CONFIG, cfg_ERROR_port;
   logic [CBSEL_W-1:0] cfg_CBSEL;

   int checks = 0;
   int errors = 0;

   int ena_first, cfg_first, cfg_last, busy_fall, fail_first, ena_rises, pulses;
   logic [CBSEL_W-1:0] cbsel_at_ena;
   logic prev_ena, prev_cfg, prev_busy;

   reconfig_ctrl #(
      .CBSEL_W         (CBSEL_W),
      .DEFAULT_IMAGE   (1),
      .CNT_W           (8),
      .TIMEOUT_CYCLES  (100),
      .SETUP_CYCLES    (4),
      .PULSE_CYCLES    (16),
      .ERR_WAIT_CYCLES (32),
      .RETRY_MAX       (2)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .auto_en        (auto_en),
      .req            (req),
      .req_image      (req_image),
      .busy           (busy),
      .fail           (fail),
      .cfg_CBSEL      (cfg_CBSEL),
      .cfg_ENA        (cfg_ENA),
      .cfg_CONFIG     (cfg_CONFIG),
      .cfg_ERROR      (cfg_ERROR),
      .cfg_ERROR_port (cfg_ERROR_port)
   );

   always #5 clk = ~clk;

   task automatic clear_obs();
      ena_first = -1; cfg_first = -1; cfg_last = -1; busy_fall = -1; fail_first = -1;
      ena_rises = 0; pulses = 0; cbsel_at_ena = '0;
      prev_ena = 1'b0; prev_cfg = 1'b0; prev_busy = 1'b0;
   endtask

   task automatic observe(input int c);
      if (cfg_ENA && !prev_ena) begin
         ena_rises++;
         if (ena_first < 0) begin ena_first = c; cbsel_at_ena = cfg_CBSEL; end
      end
      if (cfg_CONFIG && !prev_cfg) begin
         pulses++;
         if (cfg_first < 0) cfg_first = c;
      end
      if (cfg_CONFIG) cfg_last = c;
      if (!busy && prev_busy && busy_fall < 0) busy_fall = c;
      if (fail && fail_first < 0) fail_first = c;
      prev_ena = cfg_ENA; prev_cfg = cfg_CONFIG; prev_busy = busy;
   endtask

   // Leaves the bench at the negedge that opens cycle 1.
   task automatic do_reset(input logic auto);
      rstn = 1'b0; req = 1'b0; req_image = '0; cfg_ERROR = 1'b0; auto_en = auto;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      clear_obs();
   endtask

   task automatic test_reset();
      rstn = 1'b0; auto_en = 1'b1; req = 1'b1; req_image = 2'd3; cfg_ERROR = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, fail, cfg_CBSEL, cfg_ENA, cfg_CONFIG, cfg_ERROR_port} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000000",
                  {busy, fail, cfg_CBSEL, cfg_ENA, cfg_CONFIG, cfg_ERROR_port});
      end
      do_reset(1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if ({busy, fail, cfg_CBSEL, cfg_ENA, cfg_CONFIG, cfg_ERROR_port} !== 7'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 0000000",
                  {busy, fail, cfg_CBSEL, cfg_ENA, cfg_CONFIG, cfg_ERROR_port});
      end
   endtask

   task automatic test_auto_switch();
      do_reset(1'b1);
      for (int c = 1; c <= 170; c++) begin
         observe(c);
         @(negedge clk);
      end
      checks++; if (ena_first !== 101) begin errors++; $display("FAIL auto_ena_cycle got %0d want 101", ena_first); end
      checks++; if (cbsel_at_ena !== 2'd1) begin errors++; $display("FAIL auto_cbsel got %0d want 1", cbsel_at_ena); end
      checks++; if (cfg_first !== 106) begin errors++; $display("FAIL auto_config_rise got %0d want 106", cfg_first); end
      checks++; if (cfg_last !== 121) begin errors++; $display("FAIL auto_config_last got %0d want 121", cfg_last); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL auto_pulse_count got %0d want 1", pulses); end
      checks++; if (busy_fall !== 154) begin errors++; $display("FAIL auto_busy_fall got %0d want 154", busy_fall); end
      checks++; if ({busy, cfg_ENA} !== 2'b00) begin errors++; $display("FAIL auto_end_idle got %b want 00", {busy, cfg_ENA}); end
      auto_en = 1'b0;
   endtask

   task automatic test_req_ignored();
      do_reset(1'b0);
      for (int c = 1; c <= 80; c++) begin
         observe(c);
         req = (c == 10) || (c == 12);
         req_image = (c == 10) ? 2'd3 : 2'd0;
         @(negedge clk);
      end
      req = 1'b0;
      checks++; if (ena_first !== 11) begin errors++; $display("FAIL req_ena_cycle got %0d want 11", ena_first); end
      checks++; if (cbsel_at_ena !== 2'd3) begin errors++; $display("FAIL req_cbsel got %0d want 3", cbsel_at_ena); end
      checks++; if (cfg_first !== 16) begin errors++; $display("FAIL req_config_rise got %0d want 16", cfg_first); end
      checks++; if (cfg_last !== 31) begin errors++; $display("FAIL req_config_last got %0d want 31", cfg_last); end
      checks++; if (busy_fall !== 64) begin errors++; $display("FAIL req_busy_fall got %0d want 64", busy_fall); end
      checks++; if (ena_rises !== 1) begin errors++; $display("FAIL req_sequence_count got %0d want 1", ena_rises); end
      checks++; if (cfg_CBSEL !== 2'd3) begin errors++; $display("FAIL req_cbsel_held got %0d want 3", cfg_CBSEL); end
   endtask

   task automatic test_error_fail();
      int   port_first;
      logic ena35;
      int   rises_at_fail;
      bit   done;
      do_reset(1'b0);
      port_first = -1; ena35 = 1'bx;
      for (int c = 1; c <= 100; c++) begin
         observe(c);
         if (cfg_ERROR_port && port_first < 0) port_first = c;
         if (c == 35) ena35 = cfg_ENA;
         req = (c == 10);
         req_image = 2'd2;
         cfg_ERROR = (c >= 32);
         @(negedge clk);
      end
      req = 1'b0;
      checks++; if (port_first !== 34) begin errors++; $display("FAIL err_sync_latency got %0d want 34", port_first); end
      checks++; if (ena35 !== 1'b0) begin errors++; $display("FAIL err_ena_drop got %b want 0", ena35); end
      checks++; if (pulses !== EXP_PULSES) begin errors++; $display("FAIL err_pulse_count got %0d want %0d", pulses, EXP_PULSES); end
      checks++; if (ena_rises !== EXP_PULSES) begin errors++; $display("FAIL err_ena_count got %0d want %0d", ena_rises, EXP_PULSES); end
      checks++; if (fail_first !== EXP_FAIL) begin errors++; $display("FAIL err_fail_cycle got %0d want %0d", fail_first, EXP_FAIL); end
      checks++; if ({fail, busy, cfg_ENA} !== 3'b100) begin errors++; $display("FAIL err_fail_state got %b want 100", {fail, busy, cfg_ENA}); end

      // Auto-switch must stay inhibited while fail is set.
      cfg_ERROR = 1'b0;
      auto_en = 1'b1;
      rises_at_fail = ena_rises;
      for (int c = 101; c <= 250; c++) begin
         observe(c);
         @(negedge clk);
      end
      checks++; if (ena_rises !== rises_at_fail) begin errors++; $display("FAIL fail_inhibits_auto got %0d want %0d", ena_rises, rises_at_fail); end
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL fail_sticky got %b want 1", fail); end

      req = 1'b1; req_image = 2'd1;
      @(negedge clk);
      req = 1'b0; auto_en = 1'b0;
      checks++; if ({fail, busy, cfg_ENA} !== 3'b011) begin errors++; $display("FAIL req_clears_fail got %b want 011", {fail, busy, cfg_ENA}); end

      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      checks++; if (!done) begin errors++; $display("FAIL recover_timeout got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid_pulse();
      do_reset(1'b0);
      for (int c = 1; c <= 20; c++) begin
         observe(c);
         req = (c == 10);
         req_image = 2'd3;
         @(negedge clk);
      end
      req = 1'b0;
      checks++; if (cfg_CONFIG !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse got %b want 1", cfg_CONFIG); end
      #2 rstn = 1'b0;
      #1;
      checks++; if ({cfg_CONFIG, cfg_ENA, busy} !== 3'b000) begin errors++; $display("FAIL async_reset_drop got %b want 000", {cfg_CONFIG, cfg_ENA, busy}); end
      @(negedge clk);
      rstn = 1'b1;
      clear_obs();
      for (int c = 1; c <= 150; c++) begin
         observe(c);
         @(negedge clk);
      end
      checks++; if (pulses + ena_rises !== 0) begin errors++; $display("FAIL no_pulse_after_reset got %0d want 0", pulses + ena_rises); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_midreset got %b want 0", busy); end
   endtask

   task automatic test_auto_req_collide();
      do_reset(1'b1);
      for (int c = 1; c <= 200; c++) begin
         observe(c);
         req = (c == 100);
         req_image = 2'd2;
         auto_en = (c <= 100);
         @(negedge clk);
      end
      req = 1'b0;
      checks++; if (ena_first !== 101) begin errors++; $display("FAIL collide_ena_cycle got %0d want 101", ena_first); end
      checks++; if (cbsel_at_ena !== 2'd2) begin errors++; $display("FAIL collide_cbsel got %0d want 2", cbsel_at_ena); end
      checks++; if (ena_rises !== 1) begin errors++; $display("FAIL collide_sequence_count got %0d want 1", ena_rises); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL collide_pulse_count got %0d want 1", pulses); end
      checks++; if (busy_fall !== 154) begin errors++; $display("FAIL collide_busy_fall got %0d want 154", busy_fall); end
   endtask

   initial begin
      clear_obs();
      test_reset();
      test_auto_switch();
      test_req_ignored();
      test_error_fail();
      test_reset_mid_pulse();
      test_auto_req_collide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
